// File: rtl/rfifo_arb_pkg.sv
// Shared types and width helpers for the FIFO read-port arbiter.
package rfifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Bits needed to encode values 0..n-1, never less than one bit.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rfifo_rd_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after `last`, wrapping mod NUM_REQ.
module rr_pick
    import rfifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = bits_for(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   last_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_o
);

    int               idx;
    logic [PTR_W-1:0] idx_p;
    logic             found;

    // Explicit wrap keeps the search correct for non-power-of-two NUM_REQ.
    always_comb begin
        winner_o = last_i;
        found    = 1'b0;
        idx      = 0;
        idx_p    = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            idx = int'(last_i) + i;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            idx_p = PTR_W'(idx);
            if (!found && req_i[idx_p]) begin
                found    = 1'b1;
                winner_o = idx_p;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/rfifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_REQ consumers in bursts.
module rfifo_rd_arbiter
    import rfifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  r_en,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    rdy,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy
);

    localparam int unsigned CNT_W = bits_for(MAX_BURST + 1);
    localparam int unsigned PTR_W = bits_for(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   last_q, last_d;

    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               req_g, rdy_g, pop;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

    // gnt_q is one-hot, so masking selects the granted consumer's lines.
    assign req_g = |(req & gnt_q);
    assign rdy_g = |(rdy & gnt_q);
    assign pop   = (state_q == BURST) && !empty && req_g && rdy_g;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        rd_valid_d = pop ? gnt_q : '0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any && !empty) begin
                    state_d = BURST;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (pop) begin
                    if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (!req_g || empty) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            cnt_q      <= '0;
            last_q     <= PTR_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    assign r_en     = pop;
    assign gnt      = gnt_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = data_out;
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_rfifo_rd_arbiter.sv
// Randomized scoreboard bench for rfifo_rd_arbiter against a cycle-level reference model.
module tb_rfifo_rd_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  // clock / reset / DUT
  logic                  rclk = 1'b0;
  logic                  rrst = 1'b1;
  logic                  empty = 1'b1;
  logic [DATA_WIDTH-1:0] data_out = '0;
  logic                  r_en;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    rdy = '0;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;

  always #5 rclk = ~rclk;

  rfifo_rd_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .empty    (empty),
    .data_out (data_out),
    .r_en     (r_en),
    .req      (req),
    .rdy      (rdy),
    .gnt      (gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // scoreboard state
  typedef struct {
    int                    owner;
    logic [DATA_WIDTH-1:0] data;
    int                    due;
  } exp_t;

  exp_t                  exp_q[$];
  logic [DATA_WIDTH-1:0] fifo_q[$];
  logic [DATA_WIDTH-1:0] next_word = 8'h10;
  int                    checks = 0;
  int                    errors = 0;
  int                    cyc = 0;
  logic                  pop_seen = 1'b0;

  // reference model: who owns the port, pops so far, round-robin pointer
  int   owner  = -1;
  int   npop   = 0;
  int   last_m = NUM_REQ - 1;
  logic known  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // driver: one clock cycle of stimulus plus model prediction
  task automatic cycle(input logic [NUM_REQ-1:0] req_v, input logic [NUM_REQ-1:0] rdy_v,
                       input int add, input logic rst_v);
    logic [NUM_REQ-1:0] exp_g;
    logic               exp_pop;
    logic               found;
    int                 c;
    exp_t               e;
    @(posedge rclk);
    #1;
    cyc++;
    if (pop_seen) data_out = fifo_q.pop_front();
    for (int k = 0; k < add; k++) begin
      fifo_q.push_back(next_word);
      next_word = next_word + 8'd1;
    end
    empty = (fifo_q.size() == 0);
    req   = req_v;
    rdy   = rdy_v;
    rrst  = rst_v;
    #1;
    exp_g   = (owner < 0) ? '0 : (NUM_REQ'(1) << owner);
    exp_pop = (owner >= 0) && !empty && req_v[owner] && rdy_v[owner];
    if (known) begin
      chk("gnt", 32'(gnt), 32'(exp_g));
      chk("r_en", 32'(r_en), 32'(exp_pop));
      chk("busy", 32'(busy), 32'(owner >= 0));
    end
    if (exp_pop && !rst_v && fifo_q.size() > 0) begin
      e.owner = owner;
      e.data  = fifo_q[0];
      e.due   = cyc + 1;
      exp_q.push_back(e);
    end
    pop_seen = (r_en === 1'b1) && (fifo_q.size() > 0);
    if (rst_v) begin
      owner  = -1;
      npop   = 0;
      last_m = NUM_REQ - 1;
      known  = 1'b1;
    end else if (owner < 0) begin
      if (req_v != 0 && !empty) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (last_m + k) % NUM_REQ;
          if (!found && req_v[c]) begin
            found  = 1'b1;
            owner  = c;
          end
        end
        last_m = owner;
        npop   = 0;
      end
    end else if (exp_pop) begin
      npop++;
      if (npop == MAX_BURST) owner = -1;
    end else if (!req_v[owner] || empty) begin
      owner = -1;
    end
  endtask

  task automatic run(input int n, input logic [NUM_REQ-1:0] req_v,
                     input logic [NUM_REQ-1:0] rdy_v, input int add);
    for (int i = 0; i < n; i++) cycle(req_v, rdy_v, add, 1'b0);
  endtask

  // monitor: pops the expected queue whenever a word is tagged
  initial begin
    exp_t e;
    forever begin
      @(posedge rclk);
      #3;
      if (rd_valid !== '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_valid_spurious at cycle %0d: got %0h expected 0", cyc, rd_valid);
        end else begin
          e = exp_q.pop_front();
          chk("rd_valid_tag", 32'(rd_valid), 32'(NUM_REQ'(1) << e.owner));
          chk("rd_data", 32'(rd_data), 32'(e.data));
          chk("rd_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    // reset with all requesting and data available
    cycle(4'b1111, 4'b1111, 8, 1'b1);
    cycle(4'b1111, 4'b1111, 0, 1'b1);
    // fairness: continuous traffic, FIFO kept topped up
    run(30, 4'b1111, 4'b1111, 1);
    run(3, 4'b0000, 4'b1111, 0);
    // data routing from a known FIFO image A0..A7
    fifo_q.delete();
    next_word = 8'hA0;
    cycle(4'b0000, 4'b1111, 8, 1'b1);
    run(12, 4'b0101, 4'b1111, 0);
    // empty mid-burst for consumer 1, then refill and re-arbitrate
    run(6, 4'b0010, 4'b1111, 0);
    cycle(4'b0000, 4'b1111, 2, 1'b0);
    run(6, 4'b0010, 4'b1111, 0);
    cycle(4'b1111, 4'b1111, 8, 1'b0);
    run(6, 4'b1111, 4'b1111, 0);
    run(3, 4'b0000, 4'b1111, 1);
    // stall with rdy[1] low for 3 cycles
    run(2, 4'b0010, 4'b1111, 1);
    run(3, 4'b0010, 4'b1101, 1);
    run(6, 4'b0010, 4'b1111, 1);
    run(2, 4'b0000, 4'b1111, 0);
    // request drop after one pop
    run(3, 4'b0100, 4'b1111, 1);
    run(2, 4'b0000, 4'b1111, 0);
    // reset mid-burst with a pop in the reset cycle
    run(3, 4'b1111, 4'b1111, 1);
    cycle(4'b1111, 4'b1111, 1, 1'b1);
    run(4, 4'b1111, 4'b1111, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15) | $urandom_range(0, 15)),
            int'($urandom_range(0, 2)),
            ($urandom_range(0, 99) == 0));
    end
    run(4, 4'b0000, 4'b1111, 0);
    @(posedge rclk);
    #4;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rfifo_rd_arbiter.md
# rfifo_rd_arbiter

Round-robin read-port arbiter sitting on the read-clock side of the asynchronous FIFO. It shares the single FIFO read port between NUM_REQ consumers. It grants one consumer at a time for a burst of up to MAX_BURST pops, drives the FIFO `r_en`, and tags each returned word with a one-cycle valid strobe to the consumer that popped it.

## Interface
- NUM_REQ, 4, number of consumers (≥2)
- DATA_WIDTH, 8, FIFO data width
- MAX_BURST, 4, maximum pops per grant (≥1)
- rclk  in  1  read-domain clock
- rrst  in  1  synchronous, active-high reset
- empty  in  1  registered FIFO empty flag from read-pointer handler
- data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after a pop
- r_en  out  1  FIFO read enable (pop)
- req  in  NUM_REQ  per-consumer read request, level
- rdy  in  NUM_REQ  per-consumer ready to accept a word
- gnt  out  NUM_REQ  one-hot grant, registered
- rd_valid  out  NUM_REQ  one-hot strobe: rd_data belongs to this consumer this cycle
- rd_data  out  DATA_WIDTH  returned word (pass-through of data_out)
- busy  out  1  high while state is BURST

## Operation
- FSM states: IDLE, BURST.
- IDLE: if (|req) and !empty, select winner via round-robin starting at last+1 (wrapping mod NUM_REQ). Next cycle: gnt=onehot(winner), last<=winner, cnt<=0, state<=BURST. Otherwise stay in IDLE, gnt=0.
- BURST, granted index g: pop = !empty & req[g] & rdy[g]; r_en = pop (combinational from registered state and inputs). Each pop increments cnt.
- Exit BURST to IDLE (gnt<=0) at the clock edge where any of the following holds:
  - pop with cnt==MAX_BURST-1 (burst complete);
  - req[g]==0;
  - empty==1 with no pop.
- rdy[g]==0 with req[g]=1 and !empty: stall, hold grant and cnt, no pop.
- r_en is never asserted when empty=1, in IDLE, or for a non-granted consumer.
- rd_valid: registered. rd_valid <= pop ? gnt : 0. rd_data = data_out. The tag is captured at pop time, so routing stays correct even if the grant moved by the next cycle.
- Round-robin pointer `last` updates only on grant. Reset value NUM_REQ-1, so consumer 0 has first priority.
- Width rules: cnt is clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1 while in BURST. The pointer is clog2(NUM_REQ) bits with explicit wrap (no reliance on power-of-two NUM_REQ).

## Timing
- Reset values (rrst=1 at edge): state=IDLE, gnt=0, rd_valid=0, busy=0, cnt=0, last=NUM_REQ-1. r_en=0 immediately (state-qualified).
- Grant latency: req and !empty sampled in IDLE → gnt high next cycle → first r_en in that same cycle if rdy and !empty.
- Word latency: r_en at cycle N → rd_valid/rd_data at cycle N+1.
- Re-arbitration gap: one IDLE cycle between consecutive bursts. Maximum throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Reset mid-burst: state and grant cleared at that edge. A rd_valid pending from the pop in the reset cycle is dropped, and that word is lost (consumer-visible; documented).
- Simultaneous req drop and pop-eligible in the same cycle: no pop, exit.

## Structure
- Package rfifo_arb_pkg: state enum {IDLE, BURST}, and a function computing CNT_W/PTR_W from the parameters.
- Sub-module rr_pick: combinational round-robin selector (inputs req, last; outputs winner index, any). Instantiated once.
- Everything else is in rfifo_rd_arbiter: FSM, burst counter, valid tag register.

## Test plan
- Reset: assert rrst for 2 cycles with req=4'b1111, empty=0 → gnt=0, r_en=0, rd_valid=0. First grant after release is gnt=4'b0001.
- Round-robin fairness: req=4'b1111, rdy=all-1, empty=0 permanently, MAX_BURST=4 → grants cycle 0001,0010,0100,1000,0001. Each burst has exactly 4 r_en pulses, with a 1-cycle gap between bursts.
- Data routing: FIFO preloaded with 0xA0..0xA7, req=4'b0101 → consumer 0 receives A0–A3 and consumer 2 receives A4–A7, each on its rd_valid bit, one cycle after the matching r_en.
- Empty mid-burst: granted consumer 1, FIFO holds 2 words → 2 pops, then empty=1 → exit to IDLE, no r_en while empty. Refill then re-grants by round-robin order.
- Stall: gnt=0010, rdy[1]=0 for 3 cycles → r_en=0, grant held, cnt unchanged. On rdy[1]=1 the remaining pops complete the burst to 4.
- Request drop and reset mid-burst: req[g] falls after 1 pop → exit next edge with cnt cleared. A separate run asserts rrst during BURST → gnt=0 and rd_valid=0 next cycle, and last returns to NUM_REQ-1.
